// File: rtl/uart_rx.sv
// Wishbone UART receiver: oversampled 8N1 deframer feeding a small receive FIFO,
// with DATA (offset 0) and STATUS (offset 4) registers on the data bus.
module uart_rx #(
    parameter int              AWIDTH       = 8,
    parameter logic [AWIDTH-1:0] ADDR       = 8'h70,
    parameter int              CLKS_PER_BIT = 8,
    parameter int              FIFO_DEPTH   = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_dbus_adr,
    input  logic [31:0] wb_dbus_dat,
    input  logic [3:0]  wb_dbus_sel,
    input  logic        wb_dbus_we,
    input  logic        wb_dbus_cyc,
    output logic [31:0] rdt,
    output logic        ack,
    input  logic        rx,
    output logic        rx_ready
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q;
    logic            sync1_q, sync2_q, prev_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            push_q, ferr_set_q;
    logic [7:0]      push_byte_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            overrun_q, overrun_d, ferr_q, ferr_d;
    logic            ack_q, rx_ready_q, do_pop_q, clr_ovr_q, clr_ferr_q;
    logic [31:0]     rdt_q;

    logic            sel_s, req_s, fall_s, full_s, not_empty_s;
    logic            pop_s, push_ok_s, ovr_set_s;
    logic [31:0]     status_s, rd_data_s;
    logic            unused_s;

    assign fall_s      = prev_q & ~sync2_q;
    assign full_s      = (count_q == NW'(FIFO_DEPTH));
    assign not_empty_s = (count_q != NW'(0));
    assign sel_s       = wb_dbus_cyc & (wb_dbus_adr[31:32-AWIDTH] == ADDR);
    assign req_s       = sel_s & ~ack_q;
    assign unused_s    = ^{wb_dbus_sel, wb_dbus_adr[31-AWIDTH:3], wb_dbus_adr[1:0],
                           wb_dbus_dat[31:4], wb_dbus_dat[1:0]};

    assign ack      = ack_q;
    assign rdt      = rdt_q;
    assign rx_ready = rx_ready_q;

    // Receive FSM with input synchroniser; emits one-cycle push / framing-error pulses
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            bit_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            push_q      <= 1'b0;
            push_byte_q <= 8'h00;
            ferr_set_q  <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fall_s) begin
                        state_q   <= S_START;
                        bit_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (bit_cnt_q == CW'(CLKS_PER_BIT/2 - 1)) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= 3'd0;
                        state_q   <= sync2_q ? S_IDLE : S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        bit_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= sync2_q;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        bit_cnt_q   <= '0;
                        push_q      <= sync2_q;
                        push_byte_q <= shift_q;
                        ferr_set_q  <= ~sync2_q;
                        state_q     <= S_IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read mux and FIFO/status next-state; pops and clears apply at the end of the ack cycle
    always_comb begin
        status_s = {16'h0000, 8'(count_q), 4'h0, ferr_q, overrun_q, full_s, not_empty_s};
        if (wb_dbus_adr[2]) begin
            rd_data_s = status_s;
        end else if (not_empty_s) begin
            rd_data_s = {24'h000000, mem_q[rd_ptr_q]};
        end else begin
            rd_data_s = 32'h0000_0000;
        end

        pop_s     = do_pop_q;
        push_ok_s = push_q & (~full_s | pop_s);
        ovr_set_s = push_q & full_s & ~pop_s;

        wr_ptr_d = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s     ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        // Set events win over a same-cycle software clear
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clr_ovr_q) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (ferr_set_q) begin
            ferr_d = 1'b1;
        end else if (clr_ferr_q) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
    end

    // Bus, FIFO pointer and status registers
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ack_q      <= 1'b0;
            rdt_q      <= 32'h0000_0000;
            do_pop_q   <= 1'b0;
            clr_ovr_q  <= 1'b0;
            clr_ferr_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            ack_q      <= req_s;
            rdt_q      <= (req_s & ~wb_dbus_we) ? rd_data_s : 32'h0000_0000;
            do_pop_q   <= req_s & ~wb_dbus_we & ~wb_dbus_adr[2] & not_empty_s;
            clr_ovr_q  <= req_s & wb_dbus_we & wb_dbus_adr[2] & wb_dbus_dat[2];
            clr_ferr_q <= req_s & wb_dbus_we & wb_dbus_adr[2] & wb_dbus_dat[3];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            rx_ready_q <= (count_d != NW'(0));
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge wb_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_byte_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the receiver.
module tb_uart_rx;

    localparam int          CPB   = 8;
    localparam int          DEPTH = 8;
    localparam logic [31:0] A_DAT = 32'h7000_0000;
    localparam logic [31:0] A_STA = 32'h7000_0004;

    logic        clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] rdt;
    logic        ack;
    logic        rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;

    uart_rx #(.AWIDTH(8), .ADDR(8'h70), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk(clk), .wb_rst(wb_rst), .wb_dbus_adr(adr), .wb_dbus_dat(dat),
        .wb_dbus_sel(sel), .wb_dbus_we(we), .wb_dbus_cyc(cyc),
        .rdt(rdt), .ack(ack), .rx(rx), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {16'h0000, 8'(mq.size()), 4'h0, m_ferr, m_ovr,
                mq.size() == DEPTH, mq.size() != 0};
    endfunction

    // One bus access: ack must appear exactly one cycle after cyc and only for one cycle
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic rr_ack, output logic rr_after);
        @(negedge clk);
        check("ack_before", {31'h0, ack}, 32'h0);
        adr = a; we = w; dat = d; cyc = 1'b1;
        @(posedge clk); #1;
        check("ack_rise", {31'h0, ack}, 32'h1);
        rd = rdt;
        rr_ack = rx_ready;
        @(negedge clk);
        cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_fall", {31'h0, ack}, 32'h0);
        check("rdt_idle", rdt, 32'h0);
        rr_after = rx_ready;
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] r; logic a0, a1;
        bus(A_STA, 1'b0, 32'h0, r, a0, a1);
        check(tag, r, exp_status());
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] r; logic a0, a1; logic [31:0] e;
        e = (mq.size() != 0) ? {24'h0, mq.pop_front()} : 32'h0;
        bus(A_DAT, 1'b0, 32'h0, r, a0, a1);
        check(tag, r, e);
    endtask

    task automatic wr_status(input logic [31:0] d);
        logic [31:0] r; logic a0, a1;
        bus(A_STA, 1'b1, d, r, a0, a1);
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_ferr = 1'b0;
    endtask

    // Serial 8N1 character, LSB first, followed by a short idle gap
    task automatic send(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (!stop_bit) m_ferr = 1'b1;
        else if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wb_rst = 1'b1;
        repeat (3) @(negedge clk);
        wb_rst = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        ra, rb;
        int          op;

        // Reset state
        do_reset();
        @(posedge clk); #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_rdt", rdt, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        rd_status("rst_status");

        // Single byte, then rx_ready drop after the DATA ack
        send(8'hA5, 1'b1);
        check("a5_status_const", exp_status(), 32'h0000_0101);
        rd_status("a5_status");
        bus(A_DAT, 1'b0, 32'h0, r, ra, rb);
        check("a5_data", r, 32'h0000_00A5);
        check("a5_ready_at_ack", {31'h0, ra}, 32'h1);
        check("a5_ready_after", {31'h0, rb}, 32'h0);
        void'(mq.pop_front());
        rd_status("a5_status_empty");

        // Overflow: nine bytes into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1);
        check("ovr_status_const", exp_status(), 32'h0000_0807);
        rd_status("ovr_status");
        for (int i = 1; i <= 8; i++) rd_data("ovr_data");
        rd_data("empty_data");
        wr_status(32'h4);
        rd_status("ovr_cleared");

        // Framing error, recovery, clear
        send(8'h3C, 1'b0);
        rd_status("ferr_status");
        send(8'h55, 1'b1);
        rd_data("after_ferr_data");
        wr_status(32'h8);
        rd_status("ferr_cleared");

        // Short glitch on the idle line is rejected
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (CPB * 12) @(negedge clk);
        rd_status("glitch_status");
        send(8'hC3, 1'b1);
        rd_data("post_glitch_data");

        // Foreign address is ignored
        @(negedge clk);
        adr = 32'h7100_0004; cyc = 1'b1; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bad_adr_ack", {31'h0, ack}, 32'h0);
            check("bad_adr_rdt", rdt, 32'h0);
        end
        @(negedge clk);
        cyc = 1'b0;

        // Reset in the middle of a character (line high at the reset point)
        send(8'h11, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB * 3) @(negedge clk);
        do_reset();
        repeat (CPB * 10) @(negedge clk);
        check("midrst_ready", {31'h0, rx_ready}, 32'h0);
        rd_status("midrst_status");
        send(8'h96, 1'b1);
        rd_status("midrst_status2");
        rd_data("midrst_data");

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 99));
            if (op < 45) send(8'($urandom), 1'b1);
            else if (op < 52) send(8'($urandom), 1'b0);
            else if (op < 75) rd_data("rnd_data");
            else if (op < 92) rd_status("rnd_status");
            else wr_status({28'h0, 4'($urandom)});
        end
        while (mq.size() != 0) rd_data("drain_data");
        rd_status("final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
